// File: rtl/axi_lite_reg_target.sv
// AXI4-Lite register target: ID, LED, SCRATCH and a free-running CYCLES counter.
// Independent read and write channels, one outstanding transaction on each.
module axi_lite_reg_target #(
  parameter logic [31:0] ID_VALUE  = 32'h47424F59,
  parameter int          LED_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 io_axiTarget_arvalid,
  output logic                 io_axiTarget_arready,
  input  logic [31:0]          io_axiTarget_araddr,

  output logic                 io_axiTarget_rvalid,
  input  logic                 io_axiTarget_rready,
  output logic [31:0]          io_axiTarget_rdata,
  output logic [1:0]           io_axiTarget_rresp,

  input  logic                 io_axiTarget_awvalid,
  output logic                 io_axiTarget_awready,
  input  logic [31:0]          io_axiTarget_awaddr,

  input  logic                 io_axiTarget_wvalid,
  output logic                 io_axiTarget_wready,
  input  logic [31:0]          io_axiTarget_wdata,

  output logic                 io_axiTarget_bvalid,
  input  logic                 io_axiTarget_bready,
  output logic [1:0]           io_axiTarget_bresp,

  output logic [LED_WIDTH-1:0] io_leds
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [9:0] IDX_ID      = 10'd0;
  localparam logic [9:0] IDX_LED     = 10'd1;
  localparam logic [9:0] IDX_SCRATCH = 10'd2;
  localparam logic [9:0] IDX_CYCLES  = 10'd3;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  rd_state_t            rd_state;

  logic [LED_WIDTH-1:0] led;
  logic [31:0]          scratch;
  logic [31:0]          cycles;

  logic                 aw_held;
  logic                 w_held;
  logic [9:0]           aw_idx;
  logic [31:0]          w_data;

  logic [31:0]          led_ext;
  logic [31:0]          rd_word;
  logic                 rd_err;

  // Only the word index addr[11:2] selects a register.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{io_axiTarget_araddr[31:12], io_axiTarget_araddr[1:0],
                              io_axiTarget_awaddr[31:12], io_axiTarget_awaddr[1:0]};

  assign io_leds = led;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    led_ext                 = '0;
    led_ext[LED_WIDTH-1:0]  = led;
  end

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (io_axiTarget_araddr[11:2])
      IDX_ID:      rd_word = ID_VALUE;
      IDX_LED:     rd_word = led_ext;
      IDX_SCRATCH: rd_word = scratch;
      IDX_CYCLES:  rd_word = cycles;
      default:     rd_err  = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state             <= RD_IDLE;
      io_axiTarget_arready <= 1'b0;
      io_axiTarget_rvalid  <= 1'b0;
      io_axiTarget_rdata   <= '0;
      io_axiTarget_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          io_axiTarget_arready <= 1'b1;
          if (io_axiTarget_arready && io_axiTarget_arvalid) begin
            io_axiTarget_arready <= 1'b0;
            io_axiTarget_rvalid  <= 1'b1;
            io_axiTarget_rdata   <= rd_word;
            io_axiTarget_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rd_state             <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (io_axiTarget_rready) begin
            io_axiTarget_rvalid  <= 1'b0;
            io_axiTarget_arready <= 1'b1;
            rd_state             <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write path: AW and W are held independently; the commit edge also raises bvalid.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_axiTarget_awready <= 1'b0;
      io_axiTarget_wready  <= 1'b0;
      io_axiTarget_bvalid  <= 1'b0;
      io_axiTarget_bresp   <= RESP_OKAY;
      aw_held              <= 1'b0;
      w_held               <= 1'b0;
      aw_idx               <= '0;
      w_data               <= '0;
      led                  <= '0;
      scratch              <= '0;
      cycles               <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (io_axiTarget_bvalid) begin
        if (io_axiTarget_bready) begin
          io_axiTarget_bvalid  <= 1'b0;
          io_axiTarget_awready <= 1'b1;
          io_axiTarget_wready  <= 1'b1;
        end
      end else if (aw_held && w_held) begin
        aw_held             <= 1'b0;
        w_held              <= 1'b0;
        io_axiTarget_bvalid <= 1'b1;
        io_axiTarget_bresp  <= RESP_OKAY;
        case (aw_idx)
          IDX_LED:     led     <= w_data[LED_WIDTH-1:0];
          IDX_SCRATCH: scratch <= w_data;
          IDX_CYCLES:  cycles  <= '0;
          default:     io_axiTarget_bresp <= RESP_SLVERR;
        endcase
      end else begin
        if (io_axiTarget_awready && io_axiTarget_awvalid) begin
          aw_held              <= 1'b1;
          aw_idx               <= io_axiTarget_awaddr[11:2];
          io_axiTarget_awready <= 1'b0;
        end else begin
          io_axiTarget_awready <= !aw_held;
        end
        if (io_axiTarget_wready && io_axiTarget_wvalid) begin
          w_held              <= 1'b1;
          w_data              <= io_axiTarget_wdata;
          io_axiTarget_wready <= 1'b0;
        end else begin
          io_axiTarget_wready <= !w_held;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_target.sv
// Self-checking bench for axi_lite_reg_target: vector table, directed corner
// sequences and randomized traffic against a register-map reference model.
module tb_axi_lite_reg_target;

  localparam logic [31:0] ID = 32'h47424F59;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic [3:0]  leds;

  always #5 clock = ~clock;

  axi_lite_reg_target dut (
    .clock                (clock),
    .reset                (reset),
    .io_axiTarget_arvalid (arvalid),
    .io_axiTarget_arready (arready),
    .io_axiTarget_araddr  (araddr),
    .io_axiTarget_rvalid  (rvalid),
    .io_axiTarget_rready  (rready),
    .io_axiTarget_rdata   (rdata),
    .io_axiTarget_rresp   (rresp),
    .io_axiTarget_awvalid (awvalid),
    .io_axiTarget_awready (awready),
    .io_axiTarget_awaddr  (awaddr),
    .io_axiTarget_wvalid  (wvalid),
    .io_axiTarget_wready  (wready),
    .io_axiTarget_wdata   (wdata),
    .io_axiTarget_bvalid  (bvalid),
    .io_axiTarget_bready  (bready),
    .io_axiTarget_bresp   (bresp),
    .io_leds              (leds)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus the clock count at the last CYCLES clear.
  int          ecount = 0;
  logic [31:0] mark   = '0;
  logic [3:0]  led_m  = '0;
  logic [31:0] scratch_m = '0;

  always @(posedge clock) begin
    if (reset) ecount = 0;
    else       ecount = ecount + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_read(input logic [31:0] addr, input int ec,
                            output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b00;
    case (addr[11:2])
      10'd0:   d = ID;
      10'd1:   d = {28'd0, led_m};
      10'd2:   d = scratch_m;
      10'd3:   d = 32'(ec) - mark;
      default: r = 2'b10;
    endcase
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input int ec,
                             output logic [1:0] r);
    r = 2'b00;
    case (addr[11:2])
      10'd1:   led_m = d[3:0];
      10'd2:   scratch_m = d;
      10'd3:   mark = 32'(ec);
      default: r = 2'b10;
    endcase
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall,
                         output logic [31:0] d, output logic [1:0] r,
                         output logic [31:0] exp_d, output logic [1:0] exp_r);
    int n = 0;
    araddr  = addr;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    check("arready_wait", 32'(n < 20), 32'd1);
    model_read(addr, ecount, exp_d, exp_r);
    tick();
    arvalid = 1'b0;
    check("rvalid_after_ar", 32'(rvalid), 32'd1);
    d = rdata;
    r = rresp;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("rvalid_stall", 32'(rvalid), 32'd1);
      check("rdata_stable", rdata, d);
      check("rresp_stable", 32'(rresp), 32'(r));
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_cleared", 32'(rvalid), 32'd0);
    check("arready_back", 32'(arready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d,
                          input int aw_dly, input int w_dly, input int stall,
                          output logic [1:0] r, output logic [1:0] exp_r);
    bit   aw_done = 1'b0;
    bit   w_done  = 1'b0;
    logic aw_fire, w_fire;
    int   t = 0;
    awaddr = addr;
    wdata  = d;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      check("bvalid_early", 32'(bvalid), 32'd0);
      if (w_done)  check("wready_while_held", 32'(wready), 32'd0);
      if (aw_done) check("awready_while_held", 32'(awready), 32'd0);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      if (aw_fire) aw_done = 1'b1;
      if (w_fire)  w_done  = 1'b1;
      t++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("aw_w_accept", 32'(aw_done && w_done), 32'd1);
    check("bvalid_before_commit", 32'(bvalid), 32'd0);
    tick();
    model_write(addr, d, ecount, exp_r);
    check("bvalid_commit", 32'(bvalid), 32'd1);
    r = bresp;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("bvalid_stall", 32'(bvalid), 32'd1);
      check("bresp_stable", 32'(bresp), 32'(r));
      check("awready_stall", 32'(awready), 32'd0);
      check("wready_stall", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_cleared", 32'(bvalid), 32'd0);
    check("awready_back", 32'(awready), 32'd1);
    check("wready_back", 32'(wready), 32'd1);
    check("io_leds", 32'(leds), 32'(led_m));
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw_dly;
    int          w_dly;
    int          stall;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] d, exp_d, old, r32, a;
    logic [1:0]  r, exp_r;

    vecs.push_back('{1'b1, 32'h04,   32'hFFFFFFFA, 0, 0, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h04,   32'h0,        0, 0, 5, 2'b00, 32'h0000000A});
    vecs.push_back('{1'b1, 32'h08,   32'h12345678, 3, 0, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h08,   32'h0,        0, 0, 0, 2'b00, 32'h12345678});
    vecs.push_back('{1'b0, 32'h40,   32'h0,        0, 0, 0, 2'b10, 32'h0});
    vecs.push_back('{1'b1, 32'h00,   32'hDEADBEEF, 0, 0, 5, 2'b10, 32'h0});
    vecs.push_back('{1'b0, 32'h00,   32'h0,        0, 0, 0, 2'b00, ID});
    vecs.push_back('{1'b1, 32'h1008, 32'hCAFEF00D, 0, 2, 1, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h0A,   32'h0,        0, 0, 2, 2'b00, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 32'hFFC,  32'h0,        0, 0, 0, 2'b10, 32'h0});
    vecs.push_back('{1'b1, 32'h44,   32'h00000001, 1, 1, 0, 2'b10, 32'h0});
    vecs.push_back('{1'b0, 32'h04,   32'h0,        0, 0, 0, 2'b00, 32'h0000000A});
    vecs.push_back('{1'b1, 32'hF004, 32'h00000005, 0, 0, 0, 2'b00, 32'h0});
    vecs.push_back('{1'b0, 32'h07,   32'h0,        0, 0, 0, 2'b00, 32'h00000005});

    // Reset state
    repeat (3) tick();
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_leds",    32'(leds),    32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_arready", 32'(arready), 32'd1);
    check("post_rst_awready", 32'(awready), 32'd1);
    check("post_rst_wready",  32'(wready),  32'd1);

    // ID read
    do_read(32'h0, 0, d, r, exp_d, exp_r);
    check("id_rdata", d, ID);
    check("id_rresp", 32'(r), 32'd0);

    // Vector table
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].wdata, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].stall, r, exp_r);
        check("vec_bresp", 32'(r), 32'(vecs[i].resp));
      end else begin
        do_read(vecs[i].addr, vecs[i].stall, d, r, exp_d, exp_r);
        check("vec_rresp", 32'(r), 32'(vecs[i].resp));
        check("vec_rdata", d, vecs[i].rdata);
      end
    end

    // CYCLES clear then read after 7 idle cycles: value 8 at the AR handshake
    do_write(32'h0C, 32'h12345678, 0, 0, 0, r, exp_r);
    check("cyc_bresp", 32'(r), 32'd0);
    repeat (7) tick();
    do_read(32'h0C, 0, d, r, exp_d, exp_r);
    check("cyc_window", 32'(d >= 32'd8 && d <= 32'd9), 32'd1);
    check("cyc_model", d, exp_d);

    // Same-cycle read and write of SCRATCH returns the pre-write value
    old     = scratch_m;
    awaddr  = 32'h08;
    wdata   = 32'h0BADF00D;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("conc_awready_held", 32'(awready), 32'd0);
    check("conc_arready", 32'(arready), 32'd1);
    araddr  = 32'h08;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    model_write(32'h08, 32'h0BADF00D, ecount, exp_r);
    check("conc_rvalid", 32'(rvalid), 32'd1);
    check("conc_bvalid", 32'(bvalid), 32'd1);
    check("conc_rdata_old", rdata, old);
    check("conc_bresp", 32'(bresp), 32'd0);
    rready = 1'b1;
    bready = 1'b1;
    tick();
    rready = 1'b0;
    bready = 1'b0;
    check("conc_rvalid_clr", 32'(rvalid), 32'd0);
    check("conc_bvalid_clr", 32'(bvalid), 32'd0);
    do_read(32'h08, 0, d, r, exp_d, exp_r);
    check("conc_rdata_new", d, 32'h0BADF00D);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      r32 = $urandom();
      case ($urandom_range(0, 5))
        0: a = 32'h00;
        1: a = 32'h04;
        2: a = 32'h08;
        3: a = 32'h0C;
        4: a = 32'h40;
        default: a = (r32 & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), r, exp_r);
        check("rand_bresp", 32'(r), 32'(exp_r));
      end else begin
        do_read(a, $urandom_range(0, 3), d, r, exp_d, exp_r);
        check("rand_rresp", 32'(r), 32'(exp_r));
        check("rand_rdata", d, exp_d);
      end
    end

    // Reset while a read response is pending and an address is held
    do_write(32'h04, 32'h00000007, 0, 0, 0, r, exp_r);
    awaddr  = 32'h08;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    araddr  = 32'h00;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("mid_rvalid", 32'(rvalid), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_rvalid",  32'(rvalid),  32'd0);
    check("mid_rst_leds",    32'(leds),    32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    reset     = 1'b0;
    led_m     = '0;
    scratch_m = '0;
    mark      = '0;
    tick();
    check("rel_arready", 32'(arready), 32'd1);
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_wready",  32'(wready),  32'd1);
    check("rel_rvalid",  32'(rvalid),  32'd0);
    do_write(32'h04, 32'h00000003, 4, 0, 0, r, exp_r);
    check("rel_bresp", 32'(r), 32'd0);
    do_read(32'h08, 0, d, r, exp_d, exp_r);
    check("rel_scratch", d, 32'd0);
    do_read(32'h0C, 0, d, r, exp_d, exp_r);
    check("rel_cycles", d, exp_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_target.md
AXI_LITE_REG_TARGET -- requirements
Module: axi_lite_reg_target

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h47424F59, constant returned by the ID register.
REQ-002 SHALL have parameter LED_WIDTH, default 4, width of io_leds.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have AXI4-Lite read address ports: io_axiTarget_arvalid in 1, io_axiTarget_arready out 1, io_axiTarget_araddr in 32.
REQ-006 SHALL have AXI4-Lite read data ports: io_axiTarget_rvalid out 1, io_axiTarget_rready in 1, io_axiTarget_rdata out 32, io_axiTarget_rresp out 2.
REQ-007 SHALL have AXI4-Lite write address ports: io_axiTarget_awvalid in 1, io_axiTarget_awready out 1, io_axiTarget_awaddr in 32.
REQ-008 SHALL have AXI4-Lite write data ports: io_axiTarget_wvalid in 1, io_axiTarget_wready out 1, io_axiTarget_wdata in 32.
REQ-009 SHALL have AXI4-Lite write response ports: io_axiTarget_bvalid out 1, io_axiTarget_bready in 1, io_axiTarget_bresp out 2.
REQ-010 SHALL have port io_leds, output, LED_WIDTH: LED register contents.

Function
REQ-011 SHALL decode the word index from addr[11:2]; addr[1:0] and addr[31:12] SHALL be ignored.
REQ-012 SHALL implement the register map: 0x00 ID (RO, ID_VALUE), 0x04 LED (RW, bits[LED_WIDTH-1:0], upper bits read 0), 0x08 SCRATCH (RW, 32 bit), 0x0C CYCLES (free-running 32-bit counter; any write clears it).
REQ-013 SHALL respond OKAY (2'b00) to mapped accesses, and SLVERR (2'b10) to unmapped accesses and to writes to ID, with no state change and rdata 0 on error reads.
REQ-014 SHALL increment CYCLES by 1 every cycle out of reset, wrapping 0xFFFFFFFF -> 0; a write to CYCLES SHALL make it read 0 on the following cycle, taking priority over the increment.
REQ-015 Read FSM: states RD_IDLE (arready=1) and RD_RESP (rvalid=1); the AR handshake captures rdata/rresp from the register values in that cycle and moves to RD_RESP the next cycle.
REQ-016 In RD_RESP, rvalid, rdata and rresp SHALL stay stable until rready=1; after that handshake the FSM returns to RD_IDLE (arready=1 the following cycle).
REQ-017 Write path: AW and W SHALL be accepted independently, in either order or together; awready deasserts once an address is held, and wready deasserts once data is held.
REQ-018 When both address and data are held, the register update SHALL occur on the next clock edge, with bvalid=1 and bresp valid from that same edge.
REQ-019 bvalid and bresp SHALL hold until bready=1; no new AW or W SHALL be accepted while bvalid=1; awready and wready re-assert the cycle after the B handshake.
REQ-020 One outstanding read and one outstanding write SHALL be supported concurrently; a same-cycle read and write of the same register SHALL return the pre-write value.
REQ-021 io_leds SHALL be driven directly from the LED register with no added latency.

Reset
REQ-022 While reset=1, all state SHALL clear: arready, awready, wready, rvalid, bvalid = 0; rdata = 0; rresp, bresp = 0; LED, SCRATCH, CYCLES = 0; both FSMs idle; held AW/W discarded.
REQ-023 arready, awready and wready SHALL first assert in the first cycle after reset deasserts; reset mid-transaction SHALL abort it without issuing a response.

Verification
REQ-024 Read 0x00 -> rvalid the cycle after AR handshake, rdata=0x47424F59, rresp=00.
REQ-025 Write 0x04 data 0xFFFFFFFA with AW and W in the same cycle -> bresp=00, io_leds=4'hA; read 0x04 -> 0x0000000A.
REQ-026 W 0x12345678 three cycles before AW 0x08 -> wready low after data is held, single B response, SCRATCH reads 0x12345678.
REQ-027 Read 0x40 -> rresp=10, rdata=0; write 0x00 -> bresp=10, ID unchanged.
REQ-028 bready held low for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; rready held low for 5 cycles -> rdata stable.
REQ-029 Write CYCLES, then read after N idle cycles -> value within the expected cycle window; reset asserted while rvalid=1 -> rvalid=0, LED=0, arready=1 the cycle after release.
